// File: rtl/spi_master_sched.sv
// spi_master_sched: round-robin SPI master (mode 0) shared by NUM_REQ requesters.
// Moves one DATA_WIDTH-bit word per transaction, MSB first. Each requester has
// its own active-low chip select. SCK half-period is CLK_DIV clk cycles.
//
// Handshake: a requester holds req[i] (level) with its word on its req_data
// slice. req is looked at only in IDLE, so there is no back-pressure path.
// grant[i] pulses for one cycle on the edge that captures the word. done[i]
// pulses for one cycle on the edge where rx_data takes the received word.
// rx_data then holds that word until the next done.
module spi_master_sched #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            grant,
  output logic [NUM_REQ-1:0]            done,
  output logic [DATA_WIDTH-1:0]         rx_data,
  output logic                          busy,
  output logic                          SCK,
  output logic                          MOSI,
  input  logic                          MISO,
  output logic [NUM_REQ-1:0]            CS_n
);

  localparam int CW   = $clog2(DATA_WIDTH);
  localparam int DIVW = $clog2(CLK_DIV + 1);
  localparam int PW   = $clog2(NUM_REQ);

  // r_state is the FSM state. Checkers and debug probes can reach it hierarchically.
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_HIGH, S_LOW, S_GAP} state_t;

  state_t                  r_state, w_state;
  logic [DIVW-1:0]         r_div, w_div;
  logic [CW-1:0]           r_bitcnt, w_bitcnt;
  logic [DATA_WIDTH-1:0]   r_tx, w_tx;
  logic [DATA_WIDTH-1:0]   r_rx, w_rx;
  logic [PW-1:0]           r_last, w_last;
  logic [NUM_REQ-1:0]      r_grant, w_grant;
  logic [NUM_REQ-1:0]      r_done, w_done;
  logic [DATA_WIDTH-1:0]   r_rx_data, w_rx_data;
  logic                    r_busy, w_busy;
  logic                    r_sck, w_sck;
  logic                    r_mosi, w_mosi;
  logic [NUM_REQ-1:0]      r_cs_n, w_cs_n;

  logic                    w_tick;
  logic                    w_found;
  logic [PW-1:0]           w_winner;
  logic [PW-1:0]           w_idx;
  logic [DATA_WIDTH-1:0]   w_word;
  logic [DATA_WIDTH-1:0]   w_words [NUM_REQ];

  // Split the packed TX bus into one word per requester.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_words[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  assign w_tick = (r_div == DIVW'(CLK_DIV - 1));
  assign w_word = w_words[w_winner];

  // Round-robin search starts just after the last winner. The first requester set wins.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_idx = PW'((int'(r_last) + i) % NUM_REQ);
      if (!w_found && req[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  // Next-state logic and next values for every registered output.
  always_comb begin
    w_state   = r_state;
    w_div     = r_div + DIVW'(1);
    w_bitcnt  = r_bitcnt;
    w_tx      = r_tx;
    w_rx      = r_rx;
    w_last    = r_last;
    w_grant   = '0;
    w_done    = '0;
    w_rx_data = r_rx_data;
    w_sck     = r_sck;
    w_mosi    = r_mosi;
    w_cs_n    = r_cs_n;
    unique case (r_state)
      S_IDLE: begin
        w_div = '0;
        if (w_found) begin
          w_tx              = w_word;
          w_last            = w_winner;
          w_grant[w_winner] = 1'b1;
          w_cs_n            = ~(NUM_REQ'(1) << w_winner);
          w_mosi            = w_word[DATA_WIDTH-1];
          w_bitcnt          = CW'(DATA_WIDTH - 1);
          w_state           = S_SETUP;
        end
      end
      S_SETUP, S_LOW: begin
        // SCK rising edge: the RX register samples MISO here.
        if (w_tick) begin
          w_div   = '0;
          w_sck   = 1'b1;
          w_rx    = {r_rx[DATA_WIDTH-2:0], MISO};
          w_state = S_HIGH;
        end
      end
      S_HIGH: begin
        if (w_tick) begin
          w_div = '0;
          w_sck = 1'b0;
          if (r_bitcnt != '0) begin
            w_bitcnt = r_bitcnt - CW'(1);
            w_tx     = r_tx << 1;
            w_mosi   = r_tx[DATA_WIDTH-2];
            w_state  = S_LOW;
          end else begin
            w_cs_n         = '1;
            w_mosi         = 1'b0;
            w_rx_data      = r_rx;
            w_done[r_last] = 1'b1;
            w_state        = S_GAP;
          end
        end
      end
      S_GAP: begin
        // CS stays high for one full half-period before the next arbitration.
        if (w_tick) begin
          w_div   = '0;
          w_state = S_IDLE;
        end
      end
      default: begin
        w_div   = '0;
        w_state = S_IDLE;
      end
    endcase
    w_busy = (w_state != S_IDLE);
  end

  // State and output registers. Reset puts every output back to idle, which aborts any transfer in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_div     <= '0;
      r_bitcnt  <= '0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_last    <= PW'(NUM_REQ - 1);
      r_grant   <= '0;
      r_done    <= '0;
      r_rx_data <= '0;
      r_busy    <= 1'b0;
      r_sck     <= 1'b0;
      r_mosi    <= 1'b0;
      r_cs_n    <= '1;
    end else begin
      r_state   <= w_state;
      r_div     <= w_div;
      r_bitcnt  <= w_bitcnt;
      r_tx      <= w_tx;
      r_rx      <= w_rx;
      r_last    <= w_last;
      r_grant   <= w_grant;
      r_done    <= w_done;
      r_rx_data <= w_rx_data;
      r_busy    <= w_busy;
      r_sck     <= w_sck;
      r_mosi    <= w_mosi;
      r_cs_n    <= w_cs_n;
    end
  end

  assign grant   = r_grant;
  assign done    = r_done;
  assign rx_data = r_rx_data;
  assign busy    = r_busy;
  assign SCK     = r_sck;
  assign MOSI    = r_mosi;
  assign CS_n    = r_cs_n;

endmodule
